// File: rtl/xbar_rr_nxm.sv
// -----------------------------------------------------------------------------
// xbar_rr_nxm
//
// N-master x M-slave request/acknowledge crossbar. Every slave port owns a
// small IDLE/BUSY/RESP state machine and a round-robin arbiter. The port
// serves one transaction at a time. An optional watchdog turns a missing
// s_ack into an error completion after TIMEOUT cycles in BUSY.
//
// Parameters
//   N_MASTERS  number of master ports (>= 2)
//   N_SLAVES   number of slave ports (power of two, >= 2)
//   ADDR_W     address width; the top log2(N_SLAVES) bits select the slave
//   DATA_W     data width
//   TIMEOUT    BUSY cycles before an error completion; 0 disables the watchdog
//
// Ports (packed buses, element i lives in slice [i*W +: W])
//   clk, rst          clock and synchronous active-high reset
//   m_req/m_cmd       per-master request and command (0 = read, 1 = write)
//   m_addr/m_wdata    per-master address and write data
//   m_rdata           per-master read data, non-zero only together with m_ack
//   m_ack/m_err       one-cycle completion pulse and its timeout qualifier
//   s_req/s_cmd       per-slave request and forwarded command
//   s_addr/s_wdata    per-slave forwarded address and write data
//   s_rdata/s_ack     per-slave read data and completion
// -----------------------------------------------------------------------------
module xbar_rr_nxm #(
   parameter int N_MASTERS = 2,
   parameter int N_SLAVES  = 2,
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int TIMEOUT   = 0
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [N_MASTERS-1:0]         m_req,
   input  logic [N_MASTERS-1:0]         m_cmd,
   input  logic [N_MASTERS*ADDR_W-1:0]  m_addr,
   input  logic [N_MASTERS*DATA_W-1:0]  m_wdata,
   output logic [N_MASTERS*DATA_W-1:0]  m_rdata,
   output logic [N_MASTERS-1:0]         m_ack,
   output logic [N_MASTERS-1:0]         m_err,
   output logic [N_SLAVES-1:0]          s_req,
   output logic [N_SLAVES-1:0]          s_cmd,
   output logic [N_SLAVES*ADDR_W-1:0]   s_addr,
   output logic [N_SLAVES*DATA_W-1:0]   s_wdata,
   input  logic [N_SLAVES*DATA_W-1:0]   s_rdata,
   input  logic [N_SLAVES-1:0]          s_ack
);

   localparam int SEL_W = $clog2(N_SLAVES);
   localparam int MW    = $clog2(N_MASTERS);
   // Sized to hold TIMEOUT-1, the last value before the watchdog fires,
   // so the counter never wraps within one transaction.
   localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_RESP = 2'd2
   } port_state_t;

   // Per-port completion contributions, merged onto the master side below.
   logic [N_SLAVES-1:0]        resp_vld;
   logic [N_SLAVES-1:0]        resp_err;
   logic [N_SLAVES*MW-1:0]     resp_mst;
   logic [N_SLAVES*DATA_W-1:0] resp_data;

   for (genvar j = 0; j < N_SLAVES; j++) begin : g_port
      port_state_t          state_q;
      port_state_t          state_d;
      logic [MW-1:0]        ptr_q;
      logic [MW-1:0]        win;
      logic                 found;
      logic [N_MASTERS-1:0] req_vec;
      logic                 win_cmd;
      logic [ADDR_W-1:0]    win_addr;
      logic [DATA_W-1:0]    win_wdata;
      logic                 cmd_q;
      logic [ADDR_W-1:0]    addr_q;
      logic [DATA_W-1:0]    wdata_q;
      logic [DATA_W-1:0]    rdata_q;
      logic                 err_q;
      logic [CNT_W-1:0]     cnt_q;
      logic                 timeout_hit;

      // Masters whose address decodes to this port.
      always_comb begin
         req_vec = '0;
         for (int i = 0; i < N_MASTERS; i++) begin
            req_vec[i] = m_req[i] &&
               (m_addr[i*ADDR_W + ADDR_W - SEL_W +: SEL_W] == SEL_W'(j));
         end
      end

      // Round-robin: first pass covers masters above the pointer, second
      // pass wraps to masters at or below it, so ptr_q itself has lowest
      // priority.
      always_comb begin
         found = 1'b0;
         win   = ptr_q;
         for (int i = 0; i < N_MASTERS; i++) begin
            if (!found && req_vec[i] && (i > int'(ptr_q))) begin
               found = 1'b1;
               win   = MW'(i);
            end
         end
         for (int i = 0; i < N_MASTERS; i++) begin
            if (!found && req_vec[i] && (i <= int'(ptr_q))) begin
               found = 1'b1;
               win   = MW'(i);
            end
         end
      end

      // Request fields of the winning master.
      always_comb begin
         win_cmd   = 1'b0;
         win_addr  = '0;
         win_wdata = '0;
         for (int i = 0; i < N_MASTERS; i++) begin
            if (win == MW'(i)) begin
               win_cmd   = m_cmd[i];
               win_addr  = m_addr[i*ADDR_W +: ADDR_W];
               win_wdata = m_wdata[i*DATA_W +: DATA_W];
            end
         end
      end

      assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));

      // Next-state logic. An ack in the same cycle as the watchdog wins.
      always_comb begin
         state_d = state_q;
         case (state_q)
            ST_IDLE: if (found) state_d = ST_BUSY;
            ST_BUSY: if (s_ack[j] || timeout_hit) state_d = ST_RESP;
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
         endcase
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= MW'(N_MASTERS - 1);
            cmd_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
         end else begin
            state_q <= state_d;
            case (state_q)
               ST_IDLE: begin
                  if (found) begin
                     ptr_q   <= win;
                     cmd_q   <= win_cmd;
                     addr_q  <= win_addr;
                     wdata_q <= win_wdata;
                     cnt_q   <= '0;
                  end
               end
               ST_BUSY: begin
                  if (s_ack[j]) begin
                     rdata_q <= cmd_q ? '0 : s_rdata[j*DATA_W +: DATA_W];
                     err_q   <= 1'b0;
                  end else if (timeout_hit) begin
                     rdata_q <= '0;
                     err_q   <= 1'b1;
                  end else if (TIMEOUT != 0) begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end

      assign s_req[j]                        = (state_q == ST_BUSY);
      assign s_cmd[j]                        = cmd_q;
      assign s_addr[j*ADDR_W +: ADDR_W]      = addr_q;
      assign s_wdata[j*DATA_W +: DATA_W]     = wdata_q;
      assign resp_vld[j]                     = (state_q == ST_RESP);
      assign resp_err[j]                     = err_q;
      assign resp_mst[j*MW +: MW]            = ptr_q;
      assign resp_data[j*DATA_W +: DATA_W]   = rdata_q;
   end

   // A master decodes to exactly one port, so at most one port contributes
   // to any master in a given cycle; OR-merging is therefore conflict-free.
   always_comb begin
      m_ack   = '0;
      m_err   = '0;
      m_rdata = '0;
      for (int j = 0; j < N_SLAVES; j++) begin
         for (int i = 0; i < N_MASTERS; i++) begin
            if (resp_vld[j] && (resp_mst[j*MW +: MW] == MW'(i))) begin
               m_ack[i] = 1'b1;
               m_err[i] = m_err[i] | resp_err[j];
               m_rdata[i*DATA_W +: DATA_W] = m_rdata[i*DATA_W +: DATA_W] |
                                             resp_data[j*DATA_W +: DATA_W];
            end
         end
      end
   end

endmodule

// File: tb/tb_xbar_rr_nxm.sv
// -----------------------------------------------------------------------------
// tb_xbar_rr_nxm
//
// Directed bench for xbar_rr_nxm with 4 masters, 2 slaves and TIMEOUT = 4.
// Inputs change 1 time unit after the rising edge; outputs are checked at
// the same point, well away from the next active edge.
// -----------------------------------------------------------------------------
module tb_xbar_rr_nxm;

   localparam int NM = 4;
   localparam int NS = 2;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 4;

   logic             clk;
   logic             rst;
   logic [NM-1:0]    m_req;
   logic [NM-1:0]    m_cmd;
   logic [NM*AW-1:0] m_addr;
   logic [NM*DW-1:0] m_wdata;
   logic [NM*DW-1:0] m_rdata;
   logic [NM-1:0]    m_ack;
   logic [NM-1:0]    m_err;
   logic [NS-1:0]    s_req;
   logic [NS-1:0]    s_cmd;
   logic [NS*AW-1:0] s_addr;
   logic [NS*DW-1:0] s_wdata;
   logic [NS*DW-1:0] s_rdata;
   logic [NS-1:0]    s_ack;

   int tests;
   int fails;

   xbar_rr_nxm #(
      .N_MASTERS (NM),
      .N_SLAVES  (NS),
      .ADDR_W    (AW),
      .DATA_W    (DW),
      .TIMEOUT   (TO)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .m_req   (m_req),
      .m_cmd   (m_cmd),
      .m_addr  (m_addr),
      .m_wdata (m_wdata),
      .m_rdata (m_rdata),
      .m_ack   (m_ack),
      .m_err   (m_err),
      .s_req   (s_req),
      .s_cmd   (s_cmd),
      .s_addr  (s_addr),
      .s_wdata (s_wdata),
      .s_rdata (s_rdata),
      .s_ack   (s_ack)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_m(input int i, input logic req, input logic cmd,
                        input logic [31:0] addr, input logic [31:0] wdata);
      m_req[i]            = req;
      m_cmd[i]            = cmd;
      m_addr[i*AW +: AW]  = addr;
      m_wdata[i*DW +: DW] = wdata;
   endtask

   // Safety net in case the directed sequence ever stalls.
   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish, required finish before time limit");
      $fatal(1, "bench time limit");
   end

   initial begin
      tests   = 0;
      fails   = 0;
      rst     = 1'b1;
      m_req   = '0;
      m_cmd   = '0;
      m_addr  = '0;
      m_wdata = '0;
      s_rdata = '0;
      s_ack   = '0;

      // ---------------- reset state ----------------
      tick();
      tick();
      chk("rst_s_req",   s_req,   '0);
      chk("rst_m_ack",   m_ack,   '0);
      chk("rst_m_err",   m_err,   '0);
      chk("rst_m_rdata", m_rdata[63:0], '0);
      chk("rst_s_addr",  s_addr,  '0);
      chk("rst_s_cmd",   s_cmd,   '0);
      chk("rst_s_wdata", s_wdata, '0);
      rst = 1'b0;
      tick();

      // ---------------- single read, slave acks 2 cycles after s_req ----
      set_m(0, 1'b1, 1'b0, 32'h0000_0010, 32'h0);
      s_rdata[31:0] = 32'hDEAD_BEEF;
      chk("rd_t_s_req", s_req, 2'b00);
      tick();                                    // t+1
      chk("rd_t1_s_req",  s_req, 2'b01);
      chk("rd_t1_s_addr", s_addr[31:0], 32'h0000_0010);
      chk("rd_t1_s_cmd",  s_cmd[0], 1'b0);
      chk("rd_t1_rdata0", m_rdata[31:0], 32'h0);
      tick();                                    // t+2
      chk("rd_t2_m_ack",  m_ack, 4'b0000);
      chk("rd_t2_rdata0", m_rdata[31:0], 32'h0);
      tick();                                    // t+3
      s_ack[0] = 1'b1;
      chk("rd_t3_m_ack",  m_ack, 4'b0000);
      tick();                                    // t+4
      s_ack[0] = 1'b0;
      chk("rd_ack",       m_ack, 4'b0001);
      chk("rd_err",       m_err, 4'b0000);
      chk("rd_rdata0",    m_rdata[31:0], 32'hDEAD_BEEF);
      chk("rd_ack_s_req", s_req, 2'b00);
      tick();                                    // t+5
      set_m(0, 1'b0, 1'b0, 32'h0000_0010, 32'h0);
      chk("rd_t5_m_ack",  m_ack, 4'b0000);
      chk("rd_t5_rdata0", m_rdata[31:0], 32'h0);
      tick();                                    // t+6
      chk("rd_t6_s_req",  s_req, 2'b00);

      // ---------------- contention on slave 1, immediate ack ----
      s_rdata[63:32] = 32'hA5A5_0001;
      set_m(0, 1'b1, 1'b0, 32'h8000_0000, 32'h0);
      set_m(1, 1'b1, 1'b0, 32'h8000_0000, 32'h0);
      s_ack[1] = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         tick();
         if (k % 3 == 2) begin
            chk($sformatf("cont_ack_k%0d", k), m_ack,
                ((k / 3) % 2 == 0) ? 4'b0001 : 4'b0010);
            chk($sformatf("cont_rdata_k%0d", k),
                ((k / 3) % 2 == 0) ? m_rdata[31:0] : m_rdata[63:32], 32'hA5A5_0001);
         end else begin
            chk($sformatf("cont_noack_k%0d", k), m_ack, 4'b0000);
         end
         chk($sformatf("cont_sreq_k%0d", k), s_req, (k % 3 == 1) ? 2'b10 : 2'b00);
      end
      set_m(0, 1'b0, 1'b0, 32'h0, 32'h0);
      set_m(1, 1'b0, 1'b0, 32'h0, 32'h0);
      s_ack = '0;
      tick();
      tick();
      chk("cont_idle_s_req", s_req, 2'b00);

      // ---------------- parallel service of both slaves ----
      set_m(0, 1'b1, 1'b0, 32'h0000_0100, 32'h0);
      set_m(1, 1'b1, 1'b0, 32'h8000_0200, 32'h0);
      tick();
      chk("par_s_req",   s_req, 2'b11);
      chk("par_s_addr0", s_addr[31:0],  32'h0000_0100);
      chk("par_s_addr1", s_addr[63:32], 32'h8000_0200);
      s_ack   = 2'b11;
      s_rdata = {32'h2222_0000, 32'h1111_0000};
      tick();
      s_ack = '0;
      chk("par_ack",    m_ack, 4'b0011);
      chk("par_rdata0", m_rdata[31:0],  32'h1111_0000);
      chk("par_rdata1", m_rdata[63:32], 32'h2222_0000);
      tick();
      set_m(0, 1'b0, 1'b0, 32'h0, 32'h0);
      set_m(1, 1'b0, 1'b0, 32'h0, 32'h0);
      chk("par_after_ack", m_ack, 4'b0000);
      tick();

      // ---------------- write from M1 to slave 0 ----
      set_m(1, 1'b1, 1'b1, 32'h0000_0040, 32'h1234_5678);
      tick();
      chk("wr_s_req",   s_req[0], 1'b1);
      chk("wr_s_cmd",   s_cmd[0], 1'b1);
      chk("wr_s_wdata", s_wdata[31:0], 32'h1234_5678);
      chk("wr_s_addr",  s_addr[31:0],  32'h0000_0040);
      s_ack[0]      = 1'b1;
      s_rdata[31:0] = 32'hFFFF_FFFF;
      tick();
      s_ack[0] = 1'b0;
      chk("wr_ack",    m_ack, 4'b0010);
      chk("wr_err",    m_err, 4'b0000);
      chk("wr_rdata1", m_rdata[63:32], 32'h0);
      tick();
      set_m(1, 1'b0, 1'b0, 32'h0, 32'h0);
      tick();

      // ---------------- timeout on slave 1 ----
      set_m(2, 1'b1, 1'b0, 32'h8000_0004, 32'h0);
      s_rdata[63:32] = 32'hCAFE_F00D;
      for (int k = 1; k <= 5; k++) begin
         tick();
         chk($sformatf("to_ack_k%0d", k), m_ack, (k == 5) ? 4'b0100 : 4'b0000);
         chk($sformatf("to_err_k%0d", k), m_err, (k == 5) ? 4'b0100 : 4'b0000);
         chk($sformatf("to_sreq_k%0d", k), s_req, (k == 5) ? 2'b00 : 2'b10);
      end
      chk("to_rdata2", m_rdata[95:64], 32'h0);
      s_ack[1] = 1'b1;                           // late ack in RESP and IDLE
      tick();
      set_m(2, 1'b0, 1'b0, 32'h0, 32'h0);
      chk("to_late_ack_m_ack", m_ack, 4'b0000);
      tick();
      s_ack[1] = 1'b0;
      chk("to_late_ack_s_req", s_req, 2'b00);
      chk("to_late_ack_m_ack2", m_ack, 4'b0000);
      set_m(3, 1'b1, 1'b0, 32'h8000_0008, 32'h0);
      s_rdata[63:32] = 32'h3333_3333;
      tick();
      chk("to_new_s_req",  s_req, 2'b10);
      chk("to_new_s_addr", s_addr[63:32], 32'h8000_0008);
      s_ack[1] = 1'b1;
      tick();
      s_ack[1] = 1'b0;
      chk("to_new_ack",    m_ack, 4'b1000);
      chk("to_new_err",    m_err, 4'b0000);
      chk("to_new_rdata3", m_rdata[127:96], 32'h3333_3333);
      tick();
      set_m(3, 1'b0, 1'b0, 32'h0, 32'h0);
      tick();

      // ---------------- reset while BUSY, then M0 wins first ----
      set_m(1, 1'b1, 1'b0, 32'h0000_0020, 32'h0);
      tick();
      chk("rb_busy_s_req", s_req, 2'b01);
      rst = 1'b1;
      set_m(1, 1'b0, 1'b0, 32'h0, 32'h0);
      tick();
      chk("rb_s_req",  s_req, 2'b00);
      chk("rb_m_ack",  m_ack, 4'b0000);
      chk("rb_s_addr", s_addr, '0);
      rst = 1'b0;
      set_m(0, 1'b1, 1'b0, 32'h0000_0A00, 32'h0);
      set_m(1, 1'b1, 1'b0, 32'h0000_0A04, 32'h0);
      set_m(2, 1'b1, 1'b0, 32'h0000_0A08, 32'h0);
      set_m(3, 1'b1, 1'b0, 32'h0000_0A0C, 32'h0);
      tick();
      chk("rb_rel_m_ack",  m_ack, 4'b0000);
      chk("rb_rel_s_req",  s_req, 2'b01);
      chk("rb_rel_s_addr", s_addr[31:0], 32'h0000_0A00);
      s_ack[0]      = 1'b1;
      s_rdata[31:0] = 32'h0000_0055;
      tick();
      s_ack[0] = 1'b0;
      chk("rb_first_ack",   m_ack, 4'b0001);
      chk("rb_first_rdata", m_rdata[31:0], 32'h0000_0055);
      m_req = '0;
      tick();
      tick();
      chk("rb_end_s_req", s_req, 2'b00);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
